gate_truth_table_checker: RTL and testbench
===========================================

# gate_truth_table_checker

- Self-checking stimulus/compare stage wrapped around the team's NAND-derived basic-gates block.
- On a start request it drives the gate block's `a`/`b` inputs through all four input combinations and waits a programmable settle time after each.
- It then samples the five gate outputs (and, or, not, xor, xnor) and compares them against a golden truth table.
- It reports pass/fail, a saturating mismatch count and, optionally, a per-gate fail mask.

## Interface
- `SETTLE_CYCLES`, default 2: cycles each vector is held before sampling; legal range ≥1.
- `ERR_W`, default 8: width of `err_count`; legal range ≥3.
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `start` in 1: run request. Sampled only in IDLE.
- `a_drv` out 1: drives the gate block's `a` input.
- `b_drv` out 1: drives the gate block's `b` input.
- `and_in`, `or_in`, `not_in`, `xor_in`, `xnor_in` in 1 each: gate block outputs under test.
- `busy` out 1: high while a run is in progress.
- `done` out 1: one-cycle pulse at the end of a run.
- `pass` out 1: result of the last run. Held until the next accepted start.
- `err_count` out ERR_W: mismatches in the last run. Saturates at all-ones.
- `fail_mask` out 5: only when `GATE_CHK_FAIL_MASK_EN` is defined. Bit 0 and, 1 or, 2 not, 3 xor, 4 xnor.

## Operation
- States:
  - IDLE: waits for `start`.
  - SETTLE: holds the current vector for the settle time.
  - SAMPLE: compares outputs against the golden values.
  - DONE: reports the result.
- Vector order is {a,b} = 00, 01, 10, 11, held in a 2-bit index.
- Golden values: and=a&b, or=a|b, not=~a, xor=a^b, xnor=~(a^b).
- IDLE with `start`=1:
  - clear `err_count`, `pass` and `fail_mask`;
  - set index to 0, so `a_drv`/`b_drv` = 0/0;
  - load the settle counter with SETTLE_CYCLES−1;
  - go to SETTLE.
- SETTLE: decrement the counter each cycle. When it reaches 0, go to SAMPLE.
- SAMPLE:
  - compare all five inputs against the golden values for the current vector;
  - add the number of mismatches (0–5) to `err_count`, clamped to 2^ERR_W−1;
  - OR each mismatch into `fail_mask`;
  - if index = 3, go to DONE; otherwise increment the index, reload the counter and go to SETTLE.
- DONE:
  - assert `done` for this one cycle;
  - `pass` = (`err_count` = 0) including any mismatches added in the final SAMPLE;
  - go to IDLE.
- `a_drv`/`b_drv` are registered from the index. They hold their last value (1/1) in DONE and IDLE until the next start.
- `start` while `busy` is ignored and has no effect on the run. `start` held high in IDLE begins a new run each time IDLE is re-entered.
- The 8-bit count can never saturate in a single run (maximum 20 mismatches). Saturation only matters when ERR_W < 5.

## Timing
- Reset values: state IDLE, `a_drv`=0, `b_drv`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_mask`=0.
- `rst_n` low in any state returns every output to its reset value on that edge; a partial run is discarded.
- Cycle after `start` is sampled in IDLE: state SETTLE, `busy`=1, vector 00 on `a_drv`/`b_drv`.
- Each vector occupies SETTLE_CYCLES + 1 cycles: SETTLE_CYCLES in SETTLE, then 1 in SAMPLE.
- The gate-block inputs are sampled on the last SAMPLE edge, with the vector stable for SETTLE_CYCLES + 1 edges beforehand.
- `done` is high 4·(SETTLE_CYCLES+1)+1 cycles after the start edge (13 at default). In that cycle `busy`=0.
- Earliest next accepted `start` is the cycle after `done`.

## Configuration
- `GATE_CHK_FAIL_MASK_EN` defined:
  - `fail_mask` port and its 5 sticky flops are present;
  - it is cleared on accepted start and valid from the `done` cycle until the next start.
- Undefined: port and flops are absent. `err_count` and `pass` behave identically.

## Structure
- Package `gate_chk_pkg` holds:
  - state enum `gate_chk_state_t` {IDLE, SETTLE, SAMPLE, DONE};
  - gate bit-index constants GATE_AND=0 … GATE_XNOR=4;
  - vector count constant NUM_VEC=4.
- One sub-module, `gate_golden_model`: combinational a,b → 5-bit expected outputs. The comparator XORs that against the sampled 5-bit bus and popcounts the result.

## Test plan
- Real NAND-derived gate block connected, SETTLE_CYCLES=2 → `done` 13 cycles after start, `pass`=1, `err_count`=0, `fail_mask`=00000.
- `xor_in` stuck at 0 → mismatches on 01 and 10; `err_count`=2, `pass`=0, `fail_mask`=01000.
- `xor_in`/`xnor_in` swapped → `err_count`=8, `fail_mask`=11000.
- All five inputs inverted, ERR_W=3 → `err_count` saturates at 7, `pass`=0.
- `start` pulsed during SETTLE of vector 10 → no restart; `done` at the original cycle 13.
- `rst_n` low for 1 cycle during vector 10 → next cycle all outputs at reset values. A subsequent start gives a full 13-cycle run.

Source files
------------

// File: rtl/gate_truth_table_checker_pkg.sv
// Shared types and constants for the gate truth-table checker.
// Gate bit positions are used on both the golden and the sampled 5-bit buses.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } gate_chk_state_t;

  localparam int GATE_AND  = 0;
  localparam int GATE_OR   = 1;
  localparam int GATE_NOT  = 2;
  localparam int GATE_XOR  = 3;
  localparam int GATE_XNOR = 4;

  localparam int NUM_VEC = 4;

  function automatic logic [2:0] popcount5(input logic [4:0] v);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < 5; i++) begin
      cnt = cnt + 3'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/gate_truth_table_checker_golden_model.sv
// Combinational golden truth table: maps one {a,b} vector to the five
// expected gate outputs, packed by the GATE_* bit positions.
module gate_golden_model
  import gate_chk_pkg::*;
(
  input  logic       a,
  input  logic       b,
  output logic [4:0] expected
);

  always_comb begin
    expected            = '0;
    expected[GATE_AND]  = a & b;
    expected[GATE_OR]   = a | b;
    expected[GATE_NOT]  = ~a;
    expected[GATE_XOR]  = a ^ b;
    expected[GATE_XNOR] = ~(a ^ b);
  end

endmodule

// File: rtl/gate_truth_table_checker.sv
// Walks the gate block through all four {a,b} vectors and scores its outputs.
// Optional per-gate sticky fail mask enabled by GATE_CHK_FAIL_MASK_EN.
module gate_truth_table_checker
  import gate_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a_drv,
  output logic             b_drv,
  input  logic             and_in,
  input  logic             or_in,
  input  logic             not_in,
  input  logic             xor_in,
  input  logic             xnor_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count
`ifdef GATE_CHK_FAIL_MASK_EN
  ,
  output logic [4:0]       fail_mask
`endif
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W+2:0] ERR_MAX  = {3'b000, {ERR_W{1'b1}}};
  localparam logic [1:0]       LAST_VEC = 2'(NUM_VEC - 1);

  gate_chk_state_t  state, state_next;
  logic [1:0]       idx;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       expected;
  logic [4:0]       sampled;
  logic [4:0]       mism;
  logic [ERR_W+2:0] err_sum;
  logic [ERR_W-1:0] err_next;

  assign a_drv = idx[1];
  assign b_drv = idx[0];

  gate_golden_model u_golden (
    .a        (idx[1]),
    .b        (idx[0]),
    .expected (expected)
  );

  always_comb begin
    sampled            = '0;
    sampled[GATE_AND]  = and_in;
    sampled[GATE_OR]   = or_in;
    sampled[GATE_NOT]  = not_in;
    sampled[GATE_XOR]  = xor_in;
    sampled[GATE_XNOR] = xnor_in;
    mism               = sampled ^ expected;
    err_sum            = {3'b000, err_count} + {{ERR_W{1'b0}}, popcount5(mism)};
    err_next           = (err_sum > ERR_MAX) ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE:   if (start) state_next = SETTLE;
      SETTLE: begin
        busy = 1'b1;
        if (cnt == '0) state_next = SAMPLE;
      end
      SAMPLE: begin
        busy       = 1'b1;
        state_next = (idx == LAST_VEC) ? DONE : SETTLE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Vector index, settle counter and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx       <= 2'd0;
      cnt       <= '0;
      err_count <= '0;
      pass      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          idx       <= 2'd0;
          cnt       <= CNT_LOAD;
          err_count <= '0;
          pass      <= 1'b0;
        end
        SETTLE: if (cnt != '0) cnt <= cnt - 1'b1;
        SAMPLE: begin
          err_count <= err_next;
          cnt       <= CNT_LOAD;
          // pass is resolved here so it is already valid in the DONE cycle
          if (idx == LAST_VEC) pass <= (err_next == '0);
          else                 idx  <= idx + 2'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef GATE_CHK_FAIL_MASK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fail_mask <= '0;
    end else if (state == IDLE && start) begin
      fail_mask <= '0;
    end else if (state == SAMPLE) begin
      fail_mask <= fail_mask | mism;
    end
  end
`endif

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Randomised and directed bench for gate_truth_table_checker; a NAND-built gate
// stub with per-vector corruption feeds two checkers (ERR_W=8 and ERR_W=3).
module tb_gate_truth_table_checker;

  localparam int SETTLE = 2;
  localparam int P      = SETTLE + 1;
  localparam int RUNLEN = 4 * P + 1;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic a_drv, b_drv, a_drv3, b_drv3;
  logic and_in, or_in, not_in, xor_in, xnor_in;
  logic busy, done, pass, busy3, done3, pass3;
  logic [7:0] err_count;
  logic [2:0] err_count3;
`ifdef GATE_CHK_FAIL_MASK_EN
  logic [4:0] fail_mask, fail_mask3;
`endif

  logic [4:0] corrupt [4];

  int checks = 0;
  int errors = 0;

  // model state
  bit         m_run;
  int         m_k;
  logic [4:0] m_corr [4];
  logic       e_busy, e_done, e_pass;
  logic [1:0] e_ab;
  int         e_err8, e_err3;
  logic [4:0] e_mask;

  always #5 clk = ~clk;

  gate_truth_table_checker #(.SETTLE_CYCLES(SETTLE), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_drv(a_drv), .b_drv(b_drv),
    .and_in(and_in), .or_in(or_in), .not_in(not_in), .xor_in(xor_in), .xnor_in(xnor_in),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count)
`ifdef GATE_CHK_FAIL_MASK_EN
    , .fail_mask(fail_mask)
`endif
  );

  gate_truth_table_checker #(.SETTLE_CYCLES(SETTLE), .ERR_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .a_drv(a_drv3), .b_drv(b_drv3),
    .and_in(and_in), .or_in(or_in), .not_in(not_in), .xor_in(xor_in), .xnor_in(xnor_in),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err_count3)
`ifdef GATE_CHK_FAIL_MASK_EN
    , .fail_mask(fail_mask3)
`endif
  );

  // NAND-derived gate block with injectable per-vector output faults
  always_comb begin
    logic n_ab, n_aa, n_bb, x;
    n_ab = ~(a_drv & b_drv);
    n_aa = ~(a_drv & a_drv);
    n_bb = ~(b_drv & b_drv);
    x    = ~(~(a_drv & n_ab) & ~(b_drv & n_ab));
    and_in  = ~n_ab       ^ corrupt[{a_drv, b_drv}][0];
    or_in   = ~(n_aa & n_bb) ^ corrupt[{a_drv, b_drv}][1];
    not_in  = n_aa        ^ corrupt[{a_drv, b_drv}][2];
    xor_in  = x           ^ corrupt[{a_drv, b_drv}][3];
    xnor_in = ~x          ^ corrupt[{a_drv, b_drv}][4];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int ones(input logic [4:0] v);
    int n = 0;
    for (int i = 0; i < 5; i++) n += int'(v[i]);
    return n;
  endfunction

  // Advance the model by the edge just taken, then compare every output.
  task automatic step();
    int sum;
    logic [4:0] m;
    @(negedge clk);
    if (!rst_n) begin
      m_run = 0; m_k = 0; e_ab = 2'b00;
      e_err8 = 0; e_err3 = 0; e_pass = 0; e_mask = 0;
    end else if (m_run) begin
      if (m_k == RUNLEN) begin m_run = 0; m_k = 0; end
      else m_k++;
    end else if (start) begin
      m_run = 1; m_k = 1;
      for (int v = 0; v < 4; v++) m_corr[v] = corrupt[v];
    end
    e_busy = 0; e_done = 0;
    if (m_run) begin
      e_busy = (m_k <= 4 * P);
      e_done = (m_k == RUNLEN);
      e_ab   = (m_k <= 4 * P) ? 2'((m_k - 1) / P) : 2'b11;
      sum = 0; m = 0;
      for (int v = 0; v < 4; v++)
        if (P * v + P + 1 <= m_k) begin sum += ones(m_corr[v]); m |= m_corr[v]; end
      e_err8 = (sum > 255) ? 255 : sum;
      e_err3 = (sum > 7) ? 7 : sum;
      e_mask = m;
      e_pass = (m_k == RUNLEN) && (sum == 0);
    end
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("a_drv", a_drv, e_ab[1]);
    chk("b_drv", b_drv, e_ab[0]);
    chk("pass", pass, e_pass);
    chk("err_count", err_count, e_err8);
    chk("busy_w3", busy3, e_busy);
    chk("done_w3", done3, e_done);
    chk("ab_w3", {a_drv3, b_drv3}, e_ab);
    chk("pass_w3", pass3, e_pass);
    chk("err_count_w3", err_count3, e_err3);
`ifdef GATE_CHK_FAIL_MASK_EN
    chk("fail_mask", fail_mask, e_mask);
    chk("fail_mask_w3", fail_mask3, e_mask);
`endif
  endtask

  task automatic run_case(input string nm, input logic [4:0] c0, c1, c2, c3,
                          input int x_err8, input int x_err3, input logic [4:0] x_mask,
                          input bit x_pass, input bit poke);
    int t;
    bit seen;
    corrupt[0] = c0; corrupt[1] = c1; corrupt[2] = c2; corrupt[3] = c3;
    start = 1'b1;
    step();
    start = 1'b0;
    t = 1; seen = 0;
    while (!seen && t < 40) begin
      start = (poke && m_k == 2 * P + 1) ? 1'b1 : 1'b0;
      step();
      t++;
      if (done) begin
        seen = 1;
        chk({nm, "_done_latency"}, t, RUNLEN);
        chk({nm, "_err8"}, err_count, x_err8);
        chk({nm, "_err3"}, err_count3, x_err3);
        chk({nm, "_pass"}, pass, x_pass);
        chk({nm, "_busy_at_done"}, busy, 1'b0);
`ifdef GATE_CHK_FAIL_MASK_EN
        chk({nm, "_mask"}, fail_mask, x_mask);
`endif
      end
    end
    start = 1'b0;
    if (!seen) chk({nm, "_done_timeout"}, 0, 1);
    step();
    chk({nm, "_pass_held"}, pass, x_pass);
  endtask

  initial begin
    for (int v = 0; v < 4; v++) corrupt[v] = 5'b0;
    rst_n = 1'b0; start = 1'b0;
    m_run = 0; m_k = 0; e_ab = 0; e_err8 = 0; e_err3 = 0; e_pass = 0; e_mask = 0;
    step(); step();
    chk("reset_busy", busy, 1'b0);
    chk("reset_err", err_count, 0);
    rst_n = 1'b1;
    step();

    run_case("good",     5'h00, 5'h00, 5'h00, 5'h00,  0, 0, 5'b00000, 1'b1, 1'b0);
    run_case("xor_sa0",  5'h00, 5'h08, 5'h08, 5'h00,  2, 2, 5'b01000, 1'b0, 1'b0);
    run_case("swap",     5'h18, 5'h18, 5'h18, 5'h18,  8, 7, 5'b11000, 1'b0, 1'b0);
    run_case("inverted", 5'h1f, 5'h1f, 5'h1f, 5'h1f, 20, 7, 5'b11111, 1'b0, 1'b0);
    run_case("start_poke", 5'h00, 5'h00, 5'h00, 5'h00, 0, 0, 5'b00000, 1'b1, 1'b1);

    // reset in the middle of vector 10
    corrupt[1] = 5'h04;
    start = 1'b1; step(); start = 1'b0;
    while (m_k < 2 * P + 1) step();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_ab", {a_drv, b_drv}, 2'b00);
    chk("midrst_err", err_count, 0);
    chk("midrst_pass", pass, 1'b0);
    run_case("after_rst", 5'h00, 5'h00, 5'h00, 5'h00, 0, 0, 5'b00000, 1'b1, 1'b0);

    // randomised runs, stray starts and occasional resets
    for (int c = 0; c < 800; c++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      start = ($urandom_range(0, 2) == 0);
      if (!m_run)
        for (int v = 0; v < 4; v++)
          corrupt[v] = ($urandom_range(0, 1) == 0) ? 5'h00 : 5'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
